// File: rtl/edge_event_counter_pkg.sv
// Shared definitions for the edge event counter: FSM state encodings.
// Imported by the counter top so the encodings live in exactly one place.
package edge_event_counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/edge_event_counter_edge_detect.sv
// Rising-edge detector: registers the event level and flags 0->1 transitions.
// Latency: rise is combinational from in against the one-cycle-old sample; no backpressure.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_q;

  // The sample is taken every cycle regardless of FSM state, so a level held
  // across start never looks like a fresh transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/edge_event_counter.sv
// Counts rising edges of in after start until limit is reached, then pulses done.
// Latency: count/done update on the clock edge that sees the transition; no backpressure, start always wins.
module edge_event_counter
  import edge_event_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] count_nxt;
  logic             rise;

  edge_detect u_edge_detect (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .rise (rise)
  );

  // count never exceeds lim_q, so the increment cannot wrap.
  assign count_nxt = count + 1'b1;
  assign busy      = (state == COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      lim_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Restart from any state; an edge in this same cycle is dropped.
        lim_q <= limit;
        count <= '0;
        if (limit == '0) begin
          state <= FINISH;
          done  <= 1'b1;
        end else begin
          state <= COUNT;
        end
      end else begin
        case (state)
          IDLE:   state <= IDLE;
          COUNT: begin
            if (rise) begin
              count <= count_nxt;
              if (count_nxt == lim_q) begin
                done  <= 1'b1;
                state <= FINISH;
              end
            end
          end
          FINISH: state <= FINISH;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
